demux1xn_param: RTL and testbench
=================================

DEMUX1XN_PARAM -- requirements
Module: demux1xn_param

Interface
REQ-001 Parameter WIDTH, default 8, lane data width in bits (1..32).
REQ-002 Parameter LANES, default 4, number of output lanes; power of two, 2..16; PW = $clog2(LANES).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately regardless of clk.
REQ-005 in  input  WIDTH  serial data word.
REQ-006 valid  input  1  in carries a word this cycle.
REQ-007 in_ready  output  1  block can accept a word this cycle (combinational).
REQ-008 flush  input  1  close the current partial frame.
REQ-009 out_ready  output-side handshake input  1  downstream consumes frame this cycle.
REQ-010 out  output  LANES*WIDTH  frame; lane i on bits [i*WIDTH +: WIDTH].
REQ-011 valid_out  output  LANES  per-lane valid mask of the presented frame.
REQ-012 frame_valid  output  1  out/valid_out hold a frame.
REQ-013 lane_ptr  output  PW  lane the next accepted word is written to.
REQ-014 overrun  output  1  sticky: a word was offered while in_ready=0.

Function
REQ-015 Accept = valid & in_ready; accepted words are written round-robin into staging lanes 0,1,..,LANES-1, lane_ptr incrementing by one per accept, wrapping to 0.
REQ-016 Staging tracks a fill mask; a lane's mask bit sets when it is written.
REQ-017 Staging becomes "closed" when lane LANES-1 is written, or when flush=1 and fill mask (including any same-cycle accept) is nonzero.
REQ-018 flush with empty staging, or while staging already closed, has no effect; flush coinciding with the accept that fills lane LANES-1 yields one full frame, no extra frame.
REQ-019 slot_free = !frame_valid | out_ready; in_ready = !closed | slot_free.
REQ-020 Closed staging with slot_free transfers on the next edge: out lane i = staged word if mask bit i set else 0; valid_out = mask; frame_valid = 1; staging mask cleared, lane_ptr = 0.
REQ-021 Accept on the same edge as a transfer writes lane 0 of the fresh staging (mask = 1, lane_ptr = 1); full throughput of one word per cycle, no bubble, when out_ready = 1.
REQ-022 Latency: word completing a frame accepted at edge k -> frame_valid=1 with that frame after edge k+1.
REQ-023 Frame consumed at an edge where frame_valid & out_ready; frame_valid then clears unless a new frame transfers on that edge; out/valid_out hold stable while frame_valid & !out_ready.
REQ-024 Back-pressure: with frame held and staging closed, in_ready = 0; valid=1 then sets overrun, word discarded, no state change otherwise.
REQ-025 overrun clears only on reset.

Reset
REQ-026 While reset=0: out=0, valid_out=0, frame_valid=0, lane_ptr=0, overrun=0, staging mask=0, closed=0; in_ready=1 after release.
REQ-027 Reset mid-frame discards staged and presented data; first accept after release goes to lane 0.

Verification (LANES=4, WIDTH=8)
REQ-028 Reset, out_ready=1, A0,A1,A2,A3 on consecutive cycles -> one edge after A3: out={A3,A2,A1,A0}, valid_out=1111, frame_valid=1.
REQ-029 out_ready=1, 8 consecutive words 00..07 -> frames {03..00} then {07..04} on consecutive-frame edges, in_ready never 0.
REQ-030 out_ready=0, words 10..17 then 18 offered -> in_ready=0 at 18, overrun=1, 18 dropped; out_ready=1 -> {13..10} consumed then {17..14} presented.
REQ-031 B0,B1 then flush -> out={00,00,B1,B0}, valid_out=0011, lane_ptr=0.
REQ-032 C0,C1, reset pulse low, then D0..D3 -> outputs zero during reset; frame {D3,D2,D1,D0}, mask 1111, no C data.
REQ-033 E0,E1,E2, then E3 with flush same cycle -> exactly one frame {E3..E0}, mask 1111; following flush with empty staging -> no frame.

Source files
------------

// File: rtl/demux1xn_param_if.sv
// Bundle of the serial input side and the parallel frame output side of demux1xn_param.
// The master modport drives words in and consumes frames; the slave modport is the demux itself.
interface demux1xn_param_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  localparam int PW = $clog2(LANES);

  logic [WIDTH-1:0]       in;
  logic                   valid;
  logic                   in_ready;
  logic                   flush;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out;
  logic [LANES-1:0]       valid_out;
  logic                   frame_valid;
  logic [PW-1:0]          lane_ptr;
  logic                   overrun;

  modport master (
    output in, valid, flush, out_ready,
    input  in_ready, out, valid_out, frame_valid, lane_ptr, overrun
  );

  modport slave (
    input  in, valid, flush, out_ready,
    output in_ready, out, valid_out, frame_valid, lane_ptr, overrun
  );
endinterface

// File: rtl/demux1xn_param.sv
// Serial-to-parallel demux: packs accepted words round-robin into LANES staging lanes
// and presents each closed (full or flushed) group as one frame with a per-lane valid mask.
module demux1xn_param #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input logic            clk,
  input logic            reset,
  demux1xn_param_if.slave bus
);
  localparam int PW = $clog2(LANES);

  logic [WIDTH-1:0]       stage_reg [LANES];
  logic [LANES-1:0]       mask_reg, mask_next;
  logic                   closed_reg, closed_next;
  logic [PW-1:0]          ptr_reg, ptr_next;
  logic [LANES*WIDTH-1:0] out_reg, out_next;
  logic [LANES-1:0]       vout_reg;
  logic                   fv_reg;
  logic                   overrun_reg;

  logic                   slot_free;
  logic                   in_ready;
  logic                   transfer;
  logic                   accept;
  logic                   close_now;
  logic [PW-1:0]          wr_lane;
  logic [LANES-1:0]       lane_sel;
  logic [LANES-1:0]       base_mask;

  // A transfer empties staging on the same edge, so a coincident accept lands in lane 0.
  always_comb begin
    slot_free = !fv_reg | bus.out_ready;
    in_ready  = !closed_reg | slot_free;
    transfer  = closed_reg & slot_free;
    accept    = bus.valid & in_ready;
    wr_lane   = transfer ? '0 : ptr_reg;
    lane_sel  = accept ? (LANES'(1) << wr_lane) : '0;
    base_mask = transfer ? '0 : mask_reg;
    mask_next = base_mask | lane_sel;
    close_now = (accept & (wr_lane == PW'(LANES - 1)))
              | (bus.flush & !closed_reg & (|mask_next));
    closed_next = transfer ? close_now : (closed_reg | close_now);
    ptr_next = ptr_reg;
    if (transfer) ptr_next = '0;
    if (accept)   ptr_next = wr_lane + PW'(1);
    if (close_now) ptr_next = '0;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stage_reg[gi] <= '0;
      end else if (lane_sel[gi]) begin
        stage_reg[gi] <= bus.in;
      end
    end

    // Unwritten lanes of a flushed partial frame are presented as zero.
    assign out_next[gi*WIDTH +: WIDTH] = mask_reg[gi] ? stage_reg[gi] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg    <= '0;
      closed_reg  <= 1'b0;
      ptr_reg     <= '0;
      out_reg     <= '0;
      vout_reg    <= '0;
      fv_reg      <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      mask_reg   <= mask_next;
      closed_reg <= closed_next;
      ptr_reg    <= ptr_next;
      if (transfer) begin
        out_reg  <= out_next;
        vout_reg <= mask_reg;
        fv_reg   <= 1'b1;
      end else if (fv_reg & bus.out_ready) begin
        fv_reg   <= 1'b0;
      end
      if (bus.valid & !in_ready) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out         = out_reg;
  assign bus.valid_out   = vout_reg;
  assign bus.frame_valid = fv_reg;
  assign bus.lane_ptr    = ptr_reg;
  assign bus.overrun     = overrun_reg;
endmodule

// File: tb/tb_demux1xn_param.sv
// Directed and randomized checks of demux1xn_param (LANES=4, WIDTH=8) against a
// queue-based frame model.
module tb_demux1xn_param;
  localparam int W = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  demux1xn_param_if #(.WIDTH(W), .LANES(L)) bus ();

  demux1xn_param #(.WIDTH(W), .LANES(L)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: staged words in arrival order, presented frame, flags.
  logic [W-1:0]   m_stage [$];
  bit             m_closed, m_fv, m_ovr;
  logic [L*W-1:0] m_out;
  logic [L-1:0]   m_mask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_ptr();
    return m_closed ? 2'd0 : 2'(m_stage.size());
  endfunction

  task automatic check_outputs();
    chk("frame_valid", bus.frame_valid, m_fv);
    chk("lane_ptr", bus.lane_ptr, m_ptr());
    chk("overrun", bus.overrun, m_ovr);
    if (m_fv) begin
      chk("out", bus.out, m_out);
      chk("valid_out", bus.valid_out, m_mask);
    end
  endtask

  // Called at a falling edge; applies one cycle of inputs and checks across the rising edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit f, input bit ordy);
    bit was_closed, slot, inr, xfer, acc;
    bus.valid = v; bus.in = d; bus.flush = f; bus.out_ready = ordy;
    #1;
    was_closed = m_closed;
    slot = !m_fv || ordy;
    inr  = !m_closed || slot;
    xfer = m_closed && slot;
    acc  = v && inr;
    chk("in_ready", bus.in_ready, inr);
    @(posedge clk);
    if (v && !inr) m_ovr = 1'b1;
    if (xfer) begin
      m_out = '0;
      foreach (m_stage[i]) m_out[i*W +: W] = m_stage[i];
      m_mask = L'((5'd1 << m_stage.size()) - 5'd1);
      m_fv = 1'b1;
      m_stage.delete();
      m_closed = 1'b0;
    end else if (m_fv && ordy) begin
      m_fv = 1'b0;
    end
    if (acc) begin
      m_stage.push_back(d);
      if (m_stage.size() == L) m_closed = 1'b1;
    end
    if (f && !was_closed && m_stage.size() != 0) m_closed = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    bus.valid = 1'b0; bus.flush = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out", bus.out, '0);
    chk("rst_valid_out", bus.valid_out, '0);
    chk("rst_frame_valid", bus.frame_valid, 1'b0);
    chk("rst_lane_ptr", bus.lane_ptr, '0);
    chk("rst_overrun", bus.overrun, 1'b0);
    m_stage.delete();
    m_closed = 1'b0; m_fv = 1'b0; m_ovr = 1'b0; m_out = '0; m_mask = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
  endtask

  initial begin
    bus.valid = 1'b0; bus.in = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    do_reset();
    @(negedge clk);

    // Four words make one full frame one edge after the last word.
    cycle(1, 8'hA0, 0, 1); cycle(1, 8'hA1, 0, 1); cycle(1, 8'hA2, 0, 1); cycle(1, 8'hA3, 0, 1);
    cycle(0, 8'h00, 0, 1);
    chk("r028_out", bus.out, 32'hA3A2A1A0);
    chk("r028_mask", bus.valid_out, 4'hF);
    chk("r028_fv", bus.frame_valid, 1'b1);

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) cycle(1, 8'(i), 0, 1);
    cycle(0, 8'h00, 0, 1);
    chk("r029_out", bus.out, 32'h07060504);

    // Back-pressure and overrun.
    cycle(0, 8'h00, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 8'(8'h10 + i), 0, 0);
    cycle(1, 8'h18, 0, 0);
    chk("r030_overrun", bus.overrun, 1'b1);
    chk("r030_held", bus.out, 32'h13121110);
    cycle(0, 8'h00, 0, 1);
    chk("r030_next", bus.out, 32'h17161514);
    cycle(0, 8'h00, 0, 1);

    // Flush of a partial frame.
    do_reset();
    cycle(1, 8'hB0, 0, 1); cycle(1, 8'hB1, 0, 1); cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    chk("r031_out", bus.out, 32'h0000B1B0);
    chk("r031_mask", bus.valid_out, 4'h3);
    chk("r031_ptr", bus.lane_ptr, 2'd0);

    // Reset mid-frame.
    cycle(1, 8'hC0, 0, 1); cycle(1, 8'hC1, 0, 1);
    do_reset();
    cycle(1, 8'hD0, 0, 1); cycle(1, 8'hD1, 0, 1); cycle(1, 8'hD2, 0, 1); cycle(1, 8'hD3, 0, 1);
    cycle(0, 8'h00, 0, 1);
    chk("r032_out", bus.out, 32'hD3D2D1D0);
    chk("r032_mask", bus.valid_out, 4'hF);

    // Flush coinciding with the last lane, then flush on empty staging.
    cycle(1, 8'hE0, 0, 1); cycle(1, 8'hE1, 0, 1); cycle(1, 8'hE2, 0, 1); cycle(1, 8'hE3, 1, 1);
    cycle(0, 8'h00, 0, 1);
    chk("r033_out", bus.out, 32'hE3E2E1E0);
    chk("r033_mask", bus.valid_out, 4'hF);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    chk("r033_noframe", bus.frame_valid, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
